// File: rtl/lock_pkg.sv
// Shared definitions for the digital lock and its code sender: state encoding
// and default timing parameters.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRESS = 3'd1,
    GAP   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } lock_state_t;

  localparam int DEF_CODE_LEN       = 4;
  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable saturating down-counter with a terminal-count flag, used to time
// the gaps between presses and the verdict wait window.
module cycle_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/lock_code_sender.sv
// Replays a stored combination onto a digital lock's B0/B1 buttons and reports
// pass/fail/timeout. Define LOCK_SENDER_RETRY_EN to resend the code once after a fail.
//
//   state | meaning
//   IDLE  | waiting for start; result flags hold last outcome
//   PRESS | one-cycle button press for the current code bit
//   GAP   | idle spacing between presses (also before a retry)
//   WAIT  | waiting for the lock verdict, bounded by the timer
//   DONE  | one-cycle done pulse, then back to IDLE
module lock_code_sender
  import lock_pkg::*;
#(
  parameter int CODE_LEN       = DEF_CODE_LEN,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                mClk,
  input  logic                Reset,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code,
  input  logic                correct,
  input  logic                incorrect,
  output logic                B0,
  output logic                B1,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic                timeout
);

  localparam int IW = $clog2(CODE_LEN + 1);
  localparam int TW = $clog2(max_int(GAP_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDX_TOP  = IW'(CODE_LEN - 1);

`ifdef LOCK_SENDER_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  lock_state_t         state, state_n;
  logic [IW-1:0]       idx, idx_n;
  logic [CODE_LEN-1:0] code_q;
  logic [CODE_LEN-1:0] code_shift;
  logic                retry_used;
  logic                retry_ok;
  logic                accept;
  logic                press_bit;
  logic                t_load, t_en, t_tc;
  logic [TW-1:0]       t_val;
  logic                set_pass, set_fail, set_timeout, start_retry;

  assign accept     = (state == IDLE) && start;
  assign code_shift = code_q >> idx;
  assign retry_ok   = RETRY_EN && !retry_used;

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clk      (mClk),
    .rst      (Reset),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .tc       (t_tc)
  );

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    press_bit   = 1'b0;
    t_load      = 1'b0;
    t_val       = GAP_LOAD;
    t_en        = 1'b0;
    set_pass    = 1'b0;
    set_fail    = 1'b0;
    set_timeout = 1'b0;
    start_retry = 1'b0;

    // A rejection during PRESS/GAP/WAIT aborts; with retry it restarts via GAP.
    if ((state == PRESS || state == GAP || state == WAIT) && incorrect) begin
      if (retry_ok) begin
        start_retry = 1'b1;
        idx_n       = IDX_TOP;
        t_load      = 1'b1;
        t_val       = GAP_LOAD;
        state_n     = GAP;
      end else begin
        set_fail = 1'b1;
        state_n  = DONE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx_n     = IDX_TOP;
            press_bit = code[CODE_LEN-1];
            state_n   = PRESS;
          end
        end
        PRESS: begin
          t_load = 1'b1;
          if (idx == '0) begin
            t_val   = TO_LOAD;
            state_n = WAIT;
          end else begin
            t_val   = GAP_LOAD;
            idx_n   = idx - IW'(1);
            state_n = GAP;
          end
        end
        GAP: begin
          t_en = 1'b1;
          if (t_tc) begin
            press_bit = code_shift[0];
            state_n   = PRESS;
          end
        end
        WAIT: begin
          if (correct) begin
            set_pass = 1'b1;
            state_n  = DONE;
          end else begin
            t_en = 1'b1;
            if (t_tc) begin
              set_timeout = 1'b1;
              state_n     = DONE;
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge mClk) begin
    if (Reset) begin
      state      <= IDLE;
      idx        <= '0;
      code_q     <= '0;
      retry_used <= 1'b0;
      B0         <= 1'b0;
      B1         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      // Outputs are registered from the next state so they line up with it.
      B1    <= (state_n == PRESS) && press_bit;
      B0    <= (state_n == PRESS) && !press_bit;
      busy  <= (state_n == PRESS) || (state_n == GAP) || (state_n == WAIT);
      done  <= (state_n == DONE);
      if (accept) begin
        code_q     <= code;
        retry_used <= 1'b0;
        pass       <= 1'b0;
        fail       <= 1'b0;
        timeout    <= 1'b0;
      end
      if (start_retry) retry_used <= 1'b1;
      if (set_pass)    pass       <= 1'b1;
      if (set_fail)    fail       <= 1'b1;
      if (set_timeout) timeout    <= 1'b1;
    end
  end

endmodule
